ysyx_25060166_ifu: RTL and testbench

Instruction fetch unit for the RV32E core. It owns the architectural PC and issues word fetches to instruction memory over a valid/ready request/response pair. It presents each fetched instruction with its PC to the decode stage through a valid/ready handshake. It accepts control-flow redirects (jal/jalr) from the execute side, discarding any fetch made on the wrong path.

---
 rtl/ysyx_25060166_ifu_if.sv | 39 +++
 rtl/ysyx_25060166_ifu.sv | 134 +++++++++++++
 tb/tb_ysyx_25060166_ifu.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25060166_ifu_if.sv
// rtl/ysyx_25060166_ifu_if.sv - fetch unit bus bundle: imem request/response, decode handoff, redirect
// Signals:
//   imem_req_valid/imem_req_ready/imem_addr        word fetch request to instruction memory
//   imem_resp_valid/imem_resp_ready/imem_rdata     fetch response from instruction memory
//   inst_valid/inst_ready/inst/inst_pc             instruction handoff to decode
//   redirect_valid/redirect_target                 jal/jalr redirect pulse from execute
//   fetch_cnt                                      instructions delivered to decode
// Modports: master = fetch unit side, slave = memory/decode/execute side.
interface ysyx_25060166_ifu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_resp_valid;
  logic             imem_resp_ready;
  logic [WIDTH-1:0] imem_rdata;
  logic             inst_valid;
  logic             inst_ready;
  logic [WIDTH-1:0] inst;
  logic [WIDTH-1:0] inst_pc;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic [WIDTH-1:0] fetch_cnt;

  modport master (
    output imem_req_valid, imem_addr, imem_resp_ready,
    output inst_valid, inst, inst_pc, fetch_cnt,
    input  imem_req_ready, imem_resp_valid, imem_rdata,
    input  inst_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_req_valid, imem_addr, imem_resp_ready,
    input  inst_valid, inst, inst_pc, fetch_cnt,
    output imem_req_ready, imem_resp_valid, imem_rdata,
    output inst_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/ysyx_25060166_ifu.sv
// rtl/ysyx_25060166_ifu.sv - RV32E instruction fetch unit with single outstanding fetch and redirect
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    ysyx_25060166_ifu_if.master (imem request/response, decode handoff, redirect, fetch_cnt)
module ysyx_25060166_ifu #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input logic                 clk,
  input logic                 rst_n,
  ysyx_25060166_ifu_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_drop;
  logic [WIDTH-1:0] r_inst;
  logic [WIDTH-1:0] r_inst_pc;
  logic [WIDTH-1:0] r_fetch_cnt;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             w_drop_nxt;
  logic [WIDTH-1:0] w_inst_nxt;
  logic [WIDTH-1:0] w_inst_pc_nxt;
  logic [WIDTH-1:0] w_fetch_cnt_nxt;
  logic [WIDTH-1:0] w_target;

  assign w_target = bus.redirect_target & ALIGN_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      r_inst      <= '0;
      r_inst_pc   <= '0;
      r_fetch_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drop      <= w_drop_nxt;
      r_inst      <= w_inst_nxt;
      r_inst_pc   <= w_inst_pc_nxt;
      r_fetch_cnt <= w_fetch_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_drop_nxt      = r_drop;
    w_inst_nxt      = r_inst;
    w_inst_pc_nxt   = r_inst_pc;
    w_fetch_cnt_nxt = r_fetch_cnt;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end

      S_REQ: begin
        if (bus.redirect_valid) begin
          w_pc_nxt = w_target;
          // An accepted request already went out for the old pc; its response is stale.
          if (bus.imem_req_ready) begin
            w_drop_nxt  = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end else if (bus.imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.redirect_valid) begin
          w_pc_nxt = w_target;
          // If the response lands in the same cycle it is consumed here and discarded,
          // so nothing is left to drop.
          if (bus.imem_resp_valid) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_drop_nxt = 1'b1;
          end
        end else if (bus.imem_resp_valid) begin
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_inst_nxt    = bus.imem_rdata;
            w_inst_pc_nxt = r_pc;
            w_state_nxt   = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (bus.inst_ready) begin
          // The held instruction is delivered even when it is the jump itself.
          w_fetch_cnt_nxt = r_fetch_cnt + WIDTH'(1);
          w_pc_nxt        = bus.redirect_valid ? w_target : (r_pc + WIDTH'(4));
          w_state_nxt     = S_REQ;
        end else if (bus.redirect_valid) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_REQ;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.imem_req_valid  = (r_state == S_REQ);
  assign bus.imem_addr       = r_pc & ALIGN_MASK;
  assign bus.imem_resp_ready = (r_state == S_WAIT);
  assign bus.inst_valid      = (r_state == S_HOLD);
  assign bus.inst            = r_inst;
  assign bus.inst_pc         = r_inst_pc;
  assign bus.fetch_cnt       = r_fetch_cnt;

endmodule

// File: tb/tb_ysyx_25060166_ifu.sv
// tb/tb_ysyx_25060166_ifu.sv - scoreboard bench for the instruction fetch unit
module tb_ysyx_25060166_ifu;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   cyc;

  ysyx_25060166_ifu_if #(.WIDTH(32)) bus ();

  ysyx_25060166_ifu #(.WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_req[$];
  logic [63:0] exp_inst[$];

  int          mem_stall;
  int          mem_delay;
  bit          ovr_en;
  logic [31:0] ovr_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sig(input int w);
    case (w)
      0:       return bus.imem_req_valid;
      1:       return bus.imem_resp_ready;
      default: return bus.inst_valid;
    endcase
  endfunction

  task automatic wait_sig(input int w, input string nm);
    int n;
    n = 0;
    while (!sig(w) && n < 50) begin
      step();
      n++;
    end
    n_cmp++;
    if (!sig(w)) begin
      n_err++;
      $display("FAIL %s: timeout after %0d cycles expected signal high", nm, n);
    end
  endtask

  // Memory model: one outstanding request, programmable request stall and response delay.
  initial begin : mem_model
    bit          pend;
    int          dly;
    logic [31:0] paddr;
    bit          s_req;
    bit          s_resp;
    logic [31:0] s_addr;
    pend = 0; dly = 0; paddr = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_rdata      = '0;
    forever begin
      @(negedge clk);
      s_req  = bus.imem_req_valid && bus.imem_req_ready;
      s_addr = bus.imem_addr;
      s_resp = bus.imem_resp_valid && bus.imem_resp_ready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend = 0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_req_ready  = 1'b0;
        ovr_en = 1'b0;
      end else begin
        if (s_resp) begin
          pend = 0;
          bus.imem_resp_valid = 1'b0;
        end
        if (s_req) begin
          pend  = 1;
          paddr = s_addr;
          dly   = mem_delay;
        end
        if (pend && !bus.imem_resp_valid) begin
          if (dly == 0) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_rdata      = ovr_en ? ovr_data : (paddr ^ 32'hA5A5_0000);
            ovr_en = 1'b0;
          end else begin
            dly--;
          end
        end
        bus.imem_req_ready = (mem_stall == 0);
        if (bus.imem_req_valid && mem_stall > 0) mem_stall--;
      end
    end
  end

  // Scoreboard monitor: compares every accepted request and every delivered instruction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (exp_req.size() == 0) chk("req_unexpected", bus.imem_addr, 32'hxxxx_xxxx);
        else chk("req_addr", bus.imem_addr, exp_req.pop_front());
      end
      if (bus.inst_valid && bus.inst_ready) begin
        if (exp_inst.size() == 0) begin
          chk("inst_unexpected", bus.inst, 32'hxxxx_xxxx);
        end else begin
          logic [63:0] e;
          e = exp_inst.pop_front();
          chk("inst_data", bus.inst, e[63:32]);
          chk("inst_pc", bus.inst_pc, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"},  {31'd0, bus.imem_req_valid},  32'd0);
    chk({tag, "_resp_ready"}, {31'd0, bus.imem_resp_ready}, 32'd0);
    chk({tag, "_inst_valid"}, {31'd0, bus.inst_valid},      32'd0);
    chk({tag, "_fetch_cnt"},  bus.fetch_cnt,                32'd0);
    chk({tag, "_inst"},       bus.inst,                     32'd0);
    chk({tag, "_inst_pc"},    bus.inst_pc,                  32'd0);
    chk({tag, "_addr"},       bus.imem_addr,                32'h8000_0000);
  endtask

  initial begin : main
    int  t[3];
    int  req_c;
    int  wait_c;
    int  hold_c;
    bit  done;
    n_cmp = 0; n_err = 0; cyc = 0;
    mem_stall = 0; mem_delay = 0; ovr_en = 0; ovr_data = '0;
    rst_n = 1'b0;
    bus.inst_ready      = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    repeat (3) step();
    chk_reset_outputs("reset");

    // Straight-line fetch, one instruction per three cycles.
    exp_req.push_back(32'h8000_0000);
    exp_req.push_back(32'h8000_0004);
    exp_req.push_back(32'h8000_0008);
    exp_req.push_back(32'h8000_000C);
    exp_inst.push_back({32'h25A5_0000, 32'h8000_0000});
    exp_inst.push_back({32'h25A5_0004, 32'h8000_0004});
    exp_inst.push_back({32'h25A5_0008, 32'h8000_0008});
    exp_inst.push_back({32'h25A5_000C, 32'h8000_000C});
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_sig(2, "seq_inst_valid");
      t[k] = cyc;
      if (k == 2) begin
        mem_stall = 4;
        mem_delay = 3;
      end
      step();
    end
    bus.inst_ready = 1'b0;
    chk("seq_fetch_cnt", bus.fetch_cnt, 32'd3);
    chk("seq_spacing_1", t[1] - t[0], 32'd3);
    chk("seq_spacing_2", t[2] - t[1], 32'd3);

    // Backpressure on every handshake of the fetch at 0x8000000C.
    req_c = 0; wait_c = 0; hold_c = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus.imem_req_valid) begin
        req_c++;
        chk("bp_addr_stable", bus.imem_addr, 32'h8000_000C);
      end
      if (bus.imem_resp_ready) wait_c++;
      if (bus.inst_valid) begin
        hold_c++;
        if (hold_c == 1) mem_delay = 0;
        chk("bp_inst_stable", bus.inst, 32'h25A5_000C);
        chk("bp_pc_stable", bus.inst_pc, 32'h8000_000C);
        if (hold_c == 6) begin
          bus.inst_ready = 1'b1;
          done = 1;
        end
      end
      step();
    end
    bus.inst_ready = 1'b0;
    chk("bp_done", {31'd0, done}, 32'd1);
    chk("bp_req_cycles", req_c, 32'd5);
    chk("bp_wait_cycles", wait_c, 32'd4);
    chk("bp_hold_cycles", hold_c, 32'd6);
    chk("bp_fetch_cnt", bus.fetch_cnt, 32'd4);

    // Redirect in the same cycle the request at 0x80000010 is accepted.
    exp_req.push_back(32'h8000_0010);
    exp_req.push_back(32'h8000_0300);
    exp_inst.push_back({32'h25A5_0300, 32'h8000_0300});
    chk("rq_addr", bus.imem_addr, 32'h8000_0010);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h8000_0300;
    step();
    bus.redirect_valid = 1'b0;
    chk("rq_in_wait", {31'd0, bus.imem_resp_ready}, 32'd1);
    wait_sig(2, "rq_inst_valid");
    chk("rq_inst", bus.inst, 32'h25A5_0300);
    chk("rq_inst_pc", bus.inst_pc, 32'h8000_0300);
    chk("rq_fetch_cnt", bus.fetch_cnt, 32'd4);

    // Redirect consumed together with the held instruction; unaligned target.
    exp_req.push_back(32'h8000_0100);
    mem_delay = 3;
    ovr_data  = 32'hDEAD_BEEF;
    ovr_en    = 1'b1;
    bus.inst_ready      = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h8000_0103;
    step();
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("hr_addr", bus.imem_addr, 32'h8000_0100);
    chk("hr_fetch_cnt", bus.fetch_cnt, 32'd5);

    // Redirect while waiting; the 0xDEADBEEF response must be discarded.
    exp_req.push_back(32'h8000_0200);
    wait_sig(1, "wr_wait");
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h8000_0200;
    step();
    bus.redirect_valid = 1'b0;
    mem_delay = 0;
    chk("wr_still_wait", {31'd0, bus.imem_resp_ready}, 32'd1);
    wait_sig(2, "wr_inst_valid");
    chk("wr_inst", bus.inst, 32'h25A5_0200);
    chk("wr_inst_pc", bus.inst_pc, 32'h8000_0200);

    // Redirect discarding the held instruction, then pc wrap at the top of memory.
    exp_req.push_back(32'hFFFF_FFFC);
    exp_inst.push_back({32'h5A5A_FFFC, 32'hFFFF_FFFC});
    exp_req.push_back(32'h0000_0000);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    chk("dr_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("dr_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("dr_fetch_cnt", bus.fetch_cnt, 32'd5);
    wait_sig(2, "wrap_inst_valid");
    mem_delay = 5;
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    chk("wrap_fetch_cnt", bus.fetch_cnt, 32'd6);
    chk("wrap_addr", bus.imem_addr, 32'h0000_0000);

    // Reset in the middle of WAIT.
    wait_sig(1, "rs_wait");
    step();
    chk("rs_in_wait", {31'd0, bus.imem_resp_ready}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    mem_delay = 0;
    step();
    exp_req.push_back(32'h8000_0000);
    exp_inst.push_back({32'h25A5_0000, 32'h8000_0000});
    exp_req.push_back(32'h8000_0004);
    rst_n = 1'b1;
    bus.inst_ready = 1'b1;
    wait_sig(2, "rs_inst_valid");
    step();
    bus.inst_ready = 1'b0;
    chk("rs_fetch_cnt", bus.fetch_cnt, 32'd1);
    repeat (4) step();
    chk("left_req", exp_req.size(), 32'd0);
    chk("left_inst", exp_inst.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
